alu_op_issue: RTL and testbench
===============================

# alu_op_issue

Decode/issue stage that produces the `Operation`, `SrcA` and `SrcB` inputs consumed by the core's 4-bit-opcode ALU. It accepts one RV32I instruction per handshake from IF/ID, together with its PC and register-file read data. It decodes the instruction into an ALU operation code and operand pair, then holds the result in a single-entry ID/EX register with valid/ready flow control and flush. It is the sole producer of ALU opcodes in the core.

## Interface
- `DATA_WIDTH`, 32: operand/PC width.
- `OPCODE_LENGTH`, 4: width of ALU operation code.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `flush` in 1: discard held and incoming instruction (branch/jump redirect).
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `in_instr` in 32: instruction word.
- `in_pc` in DATA_WIDTH: instruction PC.
- `in_rs1_data`, `in_rs2_data` in DATA_WIDTH: register-file read data.
- `out_valid` out 1 / `out_ready` in 1: downstream (EX) handshake.
- `out_operation` out OPCODE_LENGTH: ALU opcode.
- `out_src_a`, `out_src_b` out DATA_WIDTH: ALU operands.
- `out_store_data` out DATA_WIDTH: rs2 data for stores.
- `out_rd` out 5: destination register.
- `out_reg_write` out 1: writes rd. Forced 0 when rd=x0.
- `out_branch`, `out_br_invert`, `out_jump`, `out_illegal` out 1: control flags.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, NE 1001, TRUE 1010, LT 1100, GT 1101, LTU 1110, GTU 1111.
- R-type (0110011), src_a=rs1, src_b=rs2:
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 LT, 011 LTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA.
  - Any other funct7/funct3 pair: illegal.
- I-type ALU (0010011), src_b=sign-extended imm[11:0], same funct3 mapping as R-type without SUB.
  - Shift-immediates: funct3 001/101. imm[11:5] must be 0000000 (or 0100000 for SRAI), else illegal.
- Load (0000011): ADD rs1+I-imm. Store (0100011): ADD rs1+S-imm, `out_store_data`=rs2, `out_reg_write`=0.
- Branch (1100011), src_a=rs1, src_b=rs2, `out_branch`=1, `out_reg_write`=0:
  - BEQ→EQ, BNE→NE, BLT→LT, BLTU→LTU.
  - BGE→LT and BGEU→LTU, each with `out_br_invert`=1.
  - funct3 010/011 illegal.
- LUI: ADD 0+U-imm. AUIPC: ADD pc+U-imm.
- JAL/JALR: TRUE, src_a=pc, src_b=4, `out_jump`=1.
- Illegal or unknown opcode: `out_illegal`=1, operation 0000, reg_write/branch/jump 0. The instruction still issues; a trap is raised downstream.

## Timing
- `in_ready` = !out_valid || out_ready, combinational. Capture occurs on in_valid && in_ready && !flush.
- Latency: 1 cycle from accepted input to `out_valid`=1 with decoded fields.
- Outputs are stable while out_valid && !out_ready, and change only on capture.
- Handshake cases:
  - Accept and drain in the same cycle: new entry replaces old, out_valid stays 1. Full throughput, no bubble.
  - Drain without accept: out_valid→0 next cycle.
- `flush` overrides everything. Next cycle out_valid=0 and any same-cycle input is dropped. Flush while out_valid&&out_ready counts as drained.
- Reset (rst_n=0 at a clock edge) takes effect at that edge, including mid-stall:
  - out_valid=0 and all output fields zero.
  - `in_ready`=1 once out_valid=0.

## Structure
- Package `alu_op_pkg`: ALU opcode localparams (values above), RV32I major-opcode constants, funct7 constants.
- Sub-module `alu_op_decode`: purely combinational instruction→fields decoder, including immediate generation. The top holds only the valid/ready register and flush/reset logic.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → after 1 cycle: op 0010, src_a=5, src_b=7, rd=3, reg_write=1.
- SRAI x1,x1,4 (0x4040D093) → op 0111, src_b=0x404. BGE x1,x2 → op 1100, branch=1, br_invert=1.
- LUI x5,0x12345 → op 0010, src_a=0, src_b=0x12345000. AUIPC at pc=0x100 → src_a=0x100.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen. Release → next instruction issues next cycle, no loss or duplication.
- flush with out_valid=1 and in_valid=1 → out_valid=0 next cycle, both instructions gone.
- rst_n low during stall → all outputs 0, in_ready=1. Opcode 0x7F → illegal=1, op 0000.

Source files
------------

// File: rtl/alu_op_pkg.sv
// Shared constants and payload type for the ALU decode/issue stage.
// Holds ALU opcodes, RV32I major opcodes, funct7 values and the issue payload.
package alu_op_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned OPCODE_LENGTH  = 4;
  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;

  localparam logic [OPCODE_LENGTH-1:0] ALU_AND  = 4'b0000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_OR   = 4'b0001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_XOR  = 4'b0011;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SLL  = 4'b0100;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OPCODE_LENGTH-1:0] ALU_SRA  = 4'b0111;
  localparam logic [OPCODE_LENGTH-1:0] ALU_EQ   = 4'b1000;
  localparam logic [OPCODE_LENGTH-1:0] ALU_NE   = 4'b1001;
  localparam logic [OPCODE_LENGTH-1:0] ALU_TRUE = 4'b1010;
  localparam logic [OPCODE_LENGTH-1:0] ALU_LT   = 4'b1100;
  localparam logic [OPCODE_LENGTH-1:0] ALU_GT   = 4'b1101;
  localparam logic [OPCODE_LENGTH-1:0] ALU_LTU  = 4'b1110;
  localparam logic [OPCODE_LENGTH-1:0] ALU_GTU  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0]  operation;
    logic [DATA_WIDTH-1:0]     src_a;
    logic [DATA_WIDTH-1:0]     src_b;
    logic [DATA_WIDTH-1:0]     store_data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      branch;
    logic                      br_invert;
    logic                      jump;
    logic                      illegal;
  } issue_fields_t;

  // funct3 -> ALU op for the base (funct7 = 0) integer operations.
  function automatic logic [OPCODE_LENGTH-1:0] base_alu_op(input logic [2:0] funct3);
    logic [OPCODE_LENGTH-1:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_LT;
      3'b011:  op = ALU_LTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I instruction decoder producing ALU opcode, operands
// and control flags; illegal encodings collapse to a zeroed payload.
module alu_op_decode
  import alu_op_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0]    instr,
  input  logic [DATA_WIDTH-1:0]     pc,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  output logic [OPCODE_LENGTH-1:0]  operation_c,
  output logic [DATA_WIDTH-1:0]     src_a_c,
  output logic [DATA_WIDTH-1:0]     src_b_c,
  output logic [DATA_WIDTH-1:0]     store_data_c,
  output logic [REG_ADDR_WIDTH-1:0] rd_c,
  output logic                      reg_write_c,
  output logic                      branch_c,
  output logic                      br_invert_c,
  output logic                      jump_c,
  output logic                      illegal_c
);

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [REG_ADDR_WIDTH-1:0] rd_field;
  logic [DATA_WIDTH-1:0]     imm_i;
  logic [DATA_WIDTH-1:0]     imm_s;
  logic [DATA_WIDTH-1:0]     imm_u;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_field = instr[11:7];
  assign imm_i    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u    = {instr[31:12], 12'b0};

  logic [OPCODE_LENGTH-1:0] op_v;
  logic [DATA_WIDTH-1:0]    a_v;
  logic [DATA_WIDTH-1:0]    b_v;
  logic [DATA_WIDTH-1:0]    sd_v;
  logic                     wr_v;
  logic                     br_v;
  logic                     inv_v;
  logic                     jmp_v;
  logic                     ill_v;

  // Per-opcode field selection.
  always_comb begin
    op_v  = ALU_AND;
    a_v   = '0;
    b_v   = '0;
    sd_v  = '0;
    wr_v  = 1'b0;
    br_v  = 1'b0;
    inv_v = 1'b0;
    jmp_v = 1'b0;
    ill_v = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_v  = rs1_data;
        b_v  = rs2_data;
        wr_v = 1'b1;
        if (funct7 == F7_BASE) begin
          op_v = base_alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          op_v = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          op_v = ALU_SRA;
        end else begin
          ill_v = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        a_v  = rs1_data;
        b_v  = imm_i;
        wr_v = 1'b1;
        op_v = base_alu_op(funct3);
        // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          ill_v = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            op_v = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            ill_v = 1'b1;
          end
        end
      end
      OPC_LOAD: begin
        op_v = ALU_ADD;
        a_v  = rs1_data;
        b_v  = imm_i;
        wr_v = 1'b1;
      end
      OPC_STORE: begin
        op_v = ALU_ADD;
        a_v  = rs1_data;
        b_v  = imm_s;
        sd_v = rs2_data;
      end
      OPC_BRANCH: begin
        a_v  = rs1_data;
        b_v  = rs2_data;
        br_v = 1'b1;
        case (funct3)
          3'b000:  op_v = ALU_EQ;
          3'b001:  op_v = ALU_NE;
          3'b100:  op_v = ALU_LT;
          3'b101: begin op_v = ALU_LT;  inv_v = 1'b1; end
          3'b110:  op_v = ALU_LTU;
          3'b111: begin op_v = ALU_LTU; inv_v = 1'b1; end
          default: ill_v = 1'b1;
        endcase
      end
      OPC_LUI: begin
        op_v = ALU_ADD;
        b_v  = imm_u;
        wr_v = 1'b1;
      end
      OPC_AUIPC: begin
        op_v = ALU_ADD;
        a_v  = pc;
        b_v  = imm_u;
        wr_v = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        op_v  = ALU_TRUE;
        a_v   = pc;
        b_v   = DATA_WIDTH'(4);
        wr_v  = 1'b1;
        jmp_v = 1'b1;
      end
      default: ill_v = 1'b1;
    endcase
  end

  // Illegal instructions still issue, but with an inert zeroed payload.
  always_comb begin
    operation_c  = ALU_AND;
    src_a_c      = '0;
    src_b_c      = '0;
    store_data_c = '0;
    rd_c         = '0;
    reg_write_c  = 1'b0;
    branch_c     = 1'b0;
    br_invert_c  = 1'b0;
    jump_c       = 1'b0;
    illegal_c    = ill_v;
    if (!ill_v) begin
      operation_c  = op_v;
      src_a_c      = a_v;
      src_b_c      = b_v;
      store_data_c = sd_v;
      reg_write_c  = wr_v && (rd_field != '0);
      rd_c         = reg_write_c ? rd_field : '0;
      branch_c     = br_v;
      br_invert_c  = inv_v;
      jump_c       = jmp_v;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// Decode/issue stage: decodes one instruction per handshake and holds it in a
// single-entry ID/EX register with valid/ready flow control and flush.
module alu_op_issue
  import alu_op_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_WIDTH-1:0]    in_instr,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OPCODE_LENGTH-1:0]  out_operation,
  output logic [DATA_WIDTH-1:0]     out_src_a,
  output logic [DATA_WIDTH-1:0]     out_src_b,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_branch,
  output logic                      out_br_invert,
  output logic                      out_jump,
  output logic                      out_illegal
);

  issue_fields_t dec_c;
  issue_fields_t fields_d;
  issue_fields_t fields_q;
  logic          valid_d;
  logic          valid_q;
  logic          capture_c;

  alu_op_decode u_decode (
    .instr        (in_instr),
    .pc           (in_pc),
    .rs1_data     (in_rs1_data),
    .rs2_data     (in_rs2_data),
    .operation_c  (dec_c.operation),
    .src_a_c      (dec_c.src_a),
    .src_b_c      (dec_c.src_b),
    .store_data_c (dec_c.store_data),
    .rd_c         (dec_c.rd),
    .reg_write_c  (dec_c.reg_write),
    .branch_c     (dec_c.branch),
    .br_invert_c  (dec_c.br_invert),
    .jump_c       (dec_c.jump),
    .illegal_c    (dec_c.illegal)
  );

  assign in_ready  = !valid_q || out_ready;
  assign capture_c = in_valid && in_ready && !flush;

  // Flush wins; otherwise capture refills and a lone drain empties the slot.
  always_comb begin
    valid_d  = valid_q;
    fields_d = fields_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_c) begin
      valid_d  = 1'b1;
      fields_d = dec_c;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      fields_q <= '0;
    end else begin
      valid_q  <= valid_d;
      fields_q <= fields_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_operation  = fields_q.operation;
  assign out_src_a      = fields_q.src_a;
  assign out_src_b      = fields_q.src_b;
  assign out_store_data = fields_q.store_data;
  assign out_rd         = fields_q.rd;
  assign out_reg_write  = fields_q.reg_write;
  assign out_branch     = fields_q.branch;
  assign out_br_invert  = fields_q.br_invert;
  assign out_jump       = fields_q.jump;
  assign out_illegal    = fields_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: directed instruction vectors with
// hand-computed decode results, plus stall, flush and reset scenarios.
module tb_alu_op_issue;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        inv;
    logic        j;
    logic        ill;
  } exp_t;

  localparam int NV = 16;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_operation;
  logic [31:0] out_src_a;
  logic [31:0] out_src_b;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_branch;
  logic        out_br_invert;
  logic        out_jump;
  logic        out_illegal;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  logic [31:0] v_instr[NV];
  logic [31:0] v_pc[NV];
  logic [31:0] v_rs1[NV];
  logic [31:0] v_rs2[NV];
  exp_t        v_exp[NV];

  alu_op_issue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_operation  (out_operation),
    .out_src_a      (out_src_a),
    .out_src_b      (out_src_b),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_branch     (out_branch),
    .out_br_invert  (out_br_invert),
    .out_jump       (out_jump),
    .out_illegal    (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t cur_out();
    return {out_operation, out_src_a, out_src_b, out_store_data, out_rd,
            out_reg_write, out_branch, out_br_invert, out_jump, out_illegal};
  endfunction

  task automatic check_fields(input string name, input exp_t e);
    exp_t act;
    act = cur_out();
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got op=%h a=%h b=%h sd=%h rd=%0d rw/br/inv/j/ill=%b%b%b%b%b, required op=%h a=%h b=%h sd=%h rd=%0d rw/br/inv/j/ill=%b%b%b%b%b",
               name, act.op, act.a, act.b, act.sd, act.rd, act.rw, act.br, act.inv, act.j, act.ill,
               e.op, e.a, e.b, e.sd, e.rd, e.rw, e.br, e.inv, e.j, e.ill);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic [4:0] rd,
                         input logic [4:0] flags);
    v_instr[i] = instr;
    v_pc[i]    = pc;
    v_rs1[i]   = rs1;
    v_rs2[i]   = rs2;
    v_exp[i]   = {op, a, b, sd, rd, flags};
  endtask

  task automatic drive(input int i);
    in_instr    = v_instr[i];
    in_pc       = v_pc[i];
    in_rs1_data = v_rs1[i];
    in_rs2_data = v_rs2[i];
    in_valid    = 1'b1;
  endtask

  // Present vector i until accepted; expectation is queued at the accepting edge.
  task automatic send(input int i);
    bit done;
    done = 1'b0;
    drive(i);
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(i);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout vec%0d: got in_ready stuck low, required acceptance", i);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d outstanding entries, required 0", name, sb.size());
    end
  endtask

  // Monitor: every transfer to EX is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got op=%h with empty scoreboard, required no output", out_operation);
      end else begin
        int idx;
        idx = sb.pop_front();
        check_fields($sformatf("vec%0d", idx), v_exp[idx]);
      end
    end
  end

  initial begin
    // flags = {rw, br, inv, j, ill}
    set_vec(0,  32'h002081B3, 32'h0,   32'd5,        32'd7,    4'b0010, 32'd5,        32'd7,        32'h0,    5'd3, 5'b10000);
    set_vec(1,  32'h4040D093, 32'h4,   32'h80000000, 32'h0,    4'b0111, 32'h80000000, 32'h404,      32'h0,    5'd1, 5'b10000);
    set_vec(2,  32'h0020D063, 32'h8,   32'h11,       32'h22,   4'b1100, 32'h11,       32'h22,       32'h0,    5'd0, 5'b01100);
    set_vec(3,  32'h123452B7, 32'hC,   32'hDEAD,     32'h0,    4'b0010, 32'h0,        32'h12345000, 32'h0,    5'd5, 5'b10000);
    set_vec(4,  32'h00001317, 32'h100, 32'hBEEF,     32'h0,    4'b0010, 32'h100,      32'h1000,     32'h0,    5'd6, 5'b10000);
    set_vec(5,  32'h40208233, 32'h14,  32'd10,       32'd3,    4'b0110, 32'd10,       32'd3,        32'h0,    5'd4, 5'b10000);
    set_vec(6,  32'h0020B3B3, 32'h18,  32'd1,        32'd2,    4'b1110, 32'd1,        32'd2,        32'h0,    5'd7, 5'b10000);
    set_vec(7,  32'hFFF00413, 32'h1C,  32'h0,        32'h0,    4'b0010, 32'h0,        32'hFFFFFFFF, 32'h0,    5'd8, 5'b10000);
    set_vec(8,  32'h0020A423, 32'h20,  32'h1000,     32'hCAFE, 4'b0010, 32'h1000,     32'd8,        32'hCAFE, 5'd0, 5'b00000);
    set_vec(9,  32'h0020A063, 32'h24,  32'd1,        32'd2,    4'b0000, 32'h0,        32'h0,        32'h0,    5'd0, 5'b00001);
    set_vec(10, 32'h010000EF, 32'h200, 32'h55,       32'h66,   4'b1010, 32'h200,      32'd4,        32'h0,    5'd1, 5'b10010);
    set_vec(11, 32'h00208033, 32'h2C,  32'd5,        32'd6,    4'b0010, 32'd5,        32'd6,        32'h0,    5'd0, 5'b00000);
    set_vec(12, 32'h0000007F, 32'h30,  32'h77,       32'h88,   4'b0000, 32'h0,        32'h0,        32'h0,    5'd0, 5'b00001);
    set_vec(13, 32'h02001093, 32'h34,  32'd3,        32'h0,    4'b0000, 32'h0,        32'h0,        32'h0,    5'd0, 5'b00001);
    set_vec(14, 32'h0020F063, 32'h38,  32'd3,        32'd4,    4'b1110, 32'd3,        32'd4,        32'h0,    5'd0, 5'b01100);
    set_vec(15, 32'h000100E7, 32'h300, 32'h400,      32'h0,    4'b1010, 32'h300,      32'd4,        32'h0,    5'd1, 5'b10010);

    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_fields("reset_fields", '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Back-to-back stream at full throughput.
    for (int i = 0; i < NV; i++) send(i);
    wait_drain("stream_drain");

    // Stall: held entry frozen, upstream blocked, then released without loss.
    out_ready = 1'b0;
    send(5);
    drive(6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit($sformatf("stall_in_ready%0d", k), in_ready, 1'b0);
      check_fields($sformatf("stall_hold%0d", k), v_exp[5]);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(6);
    wait_drain("stall_drain");

    // Flush with a held entry and a new input in the same cycle.
    out_ready = 1'b0;
    send(0);
    drive(3);
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    void'(sb.pop_front());
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("flush_out_valid", out_valid, 1'b0);
    check_bit("flush_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check_bit("flush_stays_empty", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Reset asserted in the middle of a stall.
    out_ready = 1'b0;
    send(10);
    drive(11);
    @(negedge clk);
    check_bit("pre_reset_stall", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    void'(sb.pop_front());
    @(negedge clk);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check_fields("midrst_fields", '0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Traffic resumes normally after reset.
    send(3);
    send(4);
    send(12);
    wait_drain("final_drain");
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
